// File: rtl/dff_link_serial_feeder.sv
// Parallel-in/serial-out framer feeding the 1-bit DFF delay link.
// Frame: start bit (~IDLE_LEVEL), data MSB-first, optional even-parity bit.
module dff_link_serial_feeder #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned PARITY_EN  = 1,
  parameter logic        IDLE_LEVEL = 1'b0
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic                  output_data,
  output logic                  frame_active,
  output logic                  word_done
);

  localparam int unsigned     CNT_W    = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_WIDTH - 1);
  localparam logic            PAR_ON   = (PARITY_EN != 0);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_START  = 2'd1,
    S_SHIFT  = 2'd2,
    S_PARITY = 2'd3
  } state_t;

  state_t                state_q, state_n;
  logic [DATA_WIDTH-1:0] shreg_q, shreg_n;
  logic [CNT_W-1:0]      cnt_q, cnt_n;
  logic                  par_q, par_n;
  logic                  od_n, fa_n, wd_n, rdy_n;
  logic                  accept;

  // State, datapath and registered outputs
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q      <= S_IDLE;
      shreg_q      <= '0;
      cnt_q        <= '0;
      par_q        <= 1'b0;
      output_data  <= IDLE_LEVEL;
      frame_active <= 1'b0;
      word_done    <= 1'b0;
      in_ready     <= 1'b1;
    end else begin
      state_q      <= state_n;
      shreg_q      <= shreg_n;
      cnt_q        <= cnt_n;
      par_q        <= par_n;
      output_data  <= od_n;
      frame_active <= fa_n;
      word_done    <= wd_n;
      in_ready     <= rdy_n;
    end
  end

  // Next state; outputs are decoded from the next state so they line up with it
  always_comb begin
    state_n = state_q;
    shreg_n = shreg_q;
    cnt_n   = cnt_q;
    par_n   = par_q;
    accept  = in_valid & in_ready;

    unique case (state_q)
      S_IDLE: ;
      S_START: begin
        state_n = S_SHIFT;
        cnt_n   = CNT_LAST;
      end
      S_SHIFT: begin
        if (cnt_q != '0) begin
          shreg_n = {shreg_q[DATA_WIDTH-2:0], 1'b0};
          cnt_n   = cnt_q - CNT_W'(1);
        end else if (PAR_ON) begin
          state_n = S_PARITY;
        end else begin
          state_n = S_IDLE;
        end
      end
      S_PARITY: state_n = S_IDLE;
      default:  state_n = S_IDLE;
    endcase

    // in_ready is only high in IDLE or the final-bit cycle, so this covers back-to-back
    if (accept) begin
      state_n = S_START;
      shreg_n = in_data;
      par_n   = ^in_data;
      cnt_n   = '0;
    end

    od_n = IDLE_LEVEL;
    unique case (state_n)
      S_IDLE:   od_n = IDLE_LEVEL;
      S_START:  od_n = ~IDLE_LEVEL;
      S_SHIFT:  od_n = shreg_n[DATA_WIDTH-1];
      S_PARITY: od_n = par_n;
      default:  od_n = IDLE_LEVEL;
    endcase

    fa_n  = (state_n != S_IDLE);
    wd_n  = (state_n == S_PARITY) || ((state_n == S_SHIFT) && (cnt_n == '0) && !PAR_ON);
    rdy_n = (state_n == S_IDLE) || wd_n;
  end

endmodule
